// File: rtl/fs_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller: FSM states and default width.
package fs_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fs_serial_sub_ctrl_fs.sv
// 1-bit full subtractor cell: dif = A - B - C, bor set when the result underflows.
module fs (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic bor,
  output logic dif
);

  assign dif = A ^ B ^ C;
  assign bor = (~A & B) | (~(A ^ B) & C);

endmodule

// File: rtl/fs_serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one fs cell fed LSB first, borrow rippled through a register.
// Handshake is start (sampled in IDLE) -> busy for WIDTH cycles -> one-cycle done pulse.
module fs_serial_sub_ctrl
  import fs_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  state_t             state;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [WIDTH-1:0]   res;
  logic               brw;
  logic [CNT_W-1:0]   count;
  logic               fs_dif;
  logic               fs_bor;
  logic [WIDTH-1:0]   res_next;
  logic               last_bit;

  fs u_fs (
    .A   (sa[0]),
    .B   (sb[0]),
    .C   (brw),
    .bor (fs_bor),
    .dif (fs_dif)
  );

  // Difference bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = {fs_dif, res[WIDTH-1:1]};
  assign last_bit = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      brw        <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            brw   <= 1'b0;
            count <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          brw   <= fs_bor;
          count <= count + CNT_W'(1);
          if (last_bit) begin
            diff       <= res_next;
            borrow_out <= fs_bor;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fs_serial_sub_ctrl.sv
// Directed and randomized checks of fs_serial_sub_ctrl against an arithmetic model (a-b, a<b).
module tb_fs_serial_sub_ctrl;

  localparam int WIDTH = 8;
  localparam int NRAND = 1000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int tests;
  int fails;
  logic [WIDTH:0] exp_q[$];

  fs_serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int unsigned d;
    d = (int'(x) - int'(y) + (1 << WIDTH)) % (1 << WIDTH);
    return {(x < y), d[WIDTH-1:0]};
  endfunction

  // Launch one operation from an idle negedge; optionally re-pulse start mid-run.
  task automatic run_op(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                        input bit inject, output int done_n, output int busy_cnt,
                        output int done_cnt);
    done_n   = 0;
    busy_cnt = 0;
    done_cnt = 0;
    a     = a_v;
    b     = b_v;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (inject && i == 4) begin
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
      end
      if (inject && i == 5) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_n == 0) done_n = i;
      end
      if (done_n != 0) break;
    end
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                          input bit inject);
    int dn, bc, dc;
    logic [WIDTH:0] e;
    e = model(a_v, b_v);
    run_op(a_v, b_v, inject, dn, bc, dc);
    check({tag, "_done_latency"}, dn, 9);
    check({tag, "_busy_cycles"}, bc, WIDTH);
    check({tag, "_done_pulses"}, dc, 1);
    check({tag, "_diff"}, diff, e[WIDTH-1:0]);
    check({tag, "_borrow"}, borrow_out, e[WIDTH]);
  endtask

  initial begin
    int dn, bc, dc, pushed;
    logic [WIDTH:0] e;
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    directed("t1", 8'h05, 8'h03, 1'b0);
    directed("t2", 8'h03, 8'h05, 1'b0);
    directed("t3a", 8'h00, 8'h01, 1'b0);
    directed("t3b", 8'hFF, 8'hFF, 1'b0);
    directed("t4", 8'h20, 8'h07, 1'b1);
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("t4_no_extra_done", dc, 0);
    check("t4_diff_held", diff, 8'h19);

    // Reset mid-run after four bits have been processed.
    a     = 8'h80;
    b     = 8'h01;
    start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_diff", diff, 0);
    check("t5_borrow", borrow_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("t5_no_done", dc, 0);
    directed("t5_after", 8'h9A, 8'h3C, 1'b0);

    // Random sweep, start held high: accepts every 10 cycles starting at the next edge.
    pushed = 0;
    for (int k = 0; k < NRAND * 10; k++) begin
      a     = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      b     = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      start = 1'b1;
      if ((k % 10) == 0 && pushed < NRAND) begin
        exp_q.push_back(model(a, b));
        pushed++;
      end
      @(negedge clk);
      check("t6_done_timing", done, ((k % 10) == 8));
      if (done) begin
        check("t6_sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("t6_result", {borrow_out, diff}, e);
        end
      end
    end
    start = 1'b0;
    check("t6_all_completed", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
